// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Drives the s/r inputs of a bank of N NOR-type SR latches. A target word
//   arrives over a valid/ready handshake. The driver works out which latches
//   need setting and which need resetting. It then issues a set pulse, a guard
//   gap, a reset pulse and a second guard gap. Empty phases are skipped. At the
//   end it checks the latch q outputs against the target.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_valid  target word presented
//   req_ready  driver can accept a target word (IDLE only)
//   req_data   target latch values [N]
//   s          registered set pulses to the latch bank [N]
//   r          registered reset pulses to the latch bank [N]
//   q_fb       latch q outputs, synchronous to clk [N]
//   done       one-cycle completion pulse
//   err        with done: q_fb differed from the target at check time
//
// PULSE_CYC and GUARD_CYC must lie in 1..15 because they are loaded into
// 4-bit down-counters.
module sr_latch_driver #(
    parameter int N         = 8,
    parameter int PULSE_CYC = 2,
    parameter int GUARD_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_data,
    output logic [N-1:0] s,
    output logic [N-1:0] r,
    input  logic [N-1:0] q_fb,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        SGRD  = 3'd2,
        RST   = 3'd3,
        RGRD  = 3'd4,
        CHECK = 3'd5
    } state_t;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GUARD_LD = 4'(GUARD_CYC - 1);

    state_t       state, state_nx;
    logic [3:0]   cnt, cnt_nx;
    logic [N-1:0] tgt, tgt_nx;
    logic [N-1:0] set_m, set_m_nx;
    logic [N-1:0] rst_m, rst_m_nx;
    logic [N-1:0] s_nx, r_nx;
    logic         done_nx, err_nx;

    assign req_ready = (state == IDLE);

    // Next-state, next-mask and next-output logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tgt_nx   = tgt;
        set_m_nx = set_m;
        rst_m_nx = rst_m;
        done_nx  = 1'b0;
        err_nx   = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    // The masks are captured once, here. Later q_fb movement
                    // during the pulses must not change what gets driven.
                    tgt_nx   = req_data;
                    set_m_nx = req_data & ~q_fb;
                    rst_m_nx = ~req_data & q_fb;
                    if (|set_m_nx) begin
                        state_nx = SET;
                        cnt_nx   = PULSE_LD;
                    end else if (|rst_m_nx) begin
                        state_nx = RST;
                        cnt_nx   = PULSE_LD;
                    end else begin
                        state_nx = CHECK;
                    end
                end
            end
            SET: begin
                if (cnt == 4'd0) begin
                    state_nx = SGRD;
                    cnt_nx   = GUARD_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            SGRD: begin
                if (cnt == 4'd0) begin
                    if (|rst_m) begin
                        state_nx = RST;
                        cnt_nx   = PULSE_LD;
                    end else begin
                        state_nx = CHECK;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RST: begin
                if (cnt == 4'd0) begin
                    state_nx = RGRD;
                    cnt_nx   = GUARD_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RGRD: begin
                if (cnt == 4'd0) begin
                    state_nx = CHECK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            CHECK: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
                err_nx   = (q_fb != tgt);
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // s and r are decoded from the next state so that both outputs can be
        // registered. They can only be high in SET or RST, so they are never
        // high together.
        s_nx = (state_nx == SET) ? set_m_nx : '0;
        r_nx = (state_nx == RST) ? rst_m_nx : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            tgt   <= '0;
            set_m <= '0;
            rst_m <= '0;
            s     <= '0;
            r     <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            tgt   <= tgt_nx;
            set_m <= set_m_nx;
            rst_m <= rst_m_nx;
            s     <= s_nx;
            r     <= r_nx;
            done  <= done_nx;
            err   <= err_nx;
        end
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous controller that drives the s/r inputs of an array of N NOR-type SR latches and reads their q outputs back.
- Accepts a target word over a valid/ready handshake and computes which latches must be set and which must be reset.
- Issues non-overlapping set and reset pulses, never asserting s and r together, then verifies q against the target.
- Sits between register logic and a latch bank; it is the initiator side of the latch s/r interface.

Parameters:
- N, 8, number of latches driven (width of s, r, q_fb, req_data).
- PULSE_CYC, 2, cycles each set or reset pulse is held high; legal range 1..15.
- GUARD_CYC, 1, all-zero cycles after each pulse phase; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  target word presented.
- req_ready  output  1  driver can accept a target word.
- req_data  input  N  target latch values.
- s  output  N  set pulses to the latch bank.
- r  output  N  reset pulses to the latch bank.
- q_fb  input  N  latch q outputs, treated as synchronous to clk.
- done  output  1  one-cycle pulse when an operation completes.
- err  output  1  valid with done; 1 means q_fb did not match the target at check time.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, s=0, r=0, done=0, err=0, req_ready=1, all internal registers 0. Reset mid-operation aborts immediately; s and r read 0 on the cycle after the reset edge, and no done is issued.
- Handshake:
  - Transfer occurs on a rising edge where req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE.
  - At transfer, latch tgt=req_data, set_m=req_data & ~q_fb, rst_m=~req_data & q_fb.
- States: IDLE, SET, SGRD, RST, RGRD, CHECK.
- From IDLE on transfer:
  - go to SET if set_m!=0;
  - else go to RST if rst_m!=0;
  - else go to CHECK.
- SET:
  - s=set_m, r=0 for exactly PULSE_CYC cycles (down-counter), then go to SGRD.
- SGRD:
  - s=0, r=0 for exactly GUARD_CYC cycles.
  - Then go to RST if rst_m!=0, else CHECK.
- RST:
  - r=rst_m, s=0 for exactly PULSE_CYC cycles, then go to RGRD.
- RGRD:
  - s=0, r=0 for GUARD_CYC cycles, then go to CHECK.
- CHECK (one cycle):
  - compare q_fb==tgt;
  - next cycle state=IDLE, done=1 for one cycle, err=(q_fb!=tgt) for that same cycle; err=0 whenever done=0.
  - req_ready returns to 1 in that same cycle, so back-to-back requests are allowed.
- Invariants:
  - (s & r)==0 on every cycle.
  - s and r are registered outputs.
  - No s or r bit is high outside SET or RST.
  - set_m and rst_m are disjoint by construction.
- Latency, transfer edge to done-high cycle:
  - both masks non-zero: 2*(PULSE_CYC+GUARD_CYC)+2 cycles;
  - one mask non-zero: PULSE_CYC+GUARD_CYC+2;
  - both masks zero: 2.
- Counters are 4 bits and load PULSE_CYC-1 or GUARD_CYC-1 on phase entry. A phase ends when the counter is 0; there is no wrap.
- req_data and req_valid are ignored outside IDLE.
- q_fb changes during pulses do not alter the latched masks.

Test Plan:
- Reset, then q_fb=0x00 and request 0xA5 (N=8, PULSE=2, GUARD=1):
  - s=0xA5 for 2 cycles, then 1 zero cycle;
  - RST phase skipped;
  - done at cycle 5 with err=0 (model sets q_fb=0xA5).
- q_fb=0xF0, request 0x3C:
  - s=0x0C for 2 cycles, 1 guard cycle, r=0xC0 for 2 cycles, 1 guard cycle;
  - done at cycle 8 with err=0;
  - (s&r)==0 on every cycle.
- q_fb=0x55, request 0x55:
  - no s or r activity;
  - done 2 cycles after transfer with err=0.
- Latch model stuck with bit 0 at 0, request 0x01:
  - s=0x01 pulse issued;
  - done with err=1.
- rst asserted during the SET phase of request 0xFF:
  - next cycle s=0, r=0, req_ready=1;
  - no done;
  - a following request 0x00 completes normally.
- Back-to-back: req_valid held high with 0x0F then 0xF0, starting from q_fb=0x00:
  - second transfer on the done cycle;
  - second operation issues s=0xF0 and r=0x0F in order.
